// File: rtl/fxyz_pkg.sv
// Shared types and constants for the x/y/z truth-table sweep controller.
package fxyz_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SETTLE_W = 4;

  // Expected table of s = (x & ~y)' & z, bit i for {x,y,z} = i.
  localparam logic [7:0] GOLDEN_TABLE = 8'h8A;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/fxyz_sweep_ctrl_settle.sv
// Settle timer: counts the cycles one input combination is held.
// last_o is high on the final settle cycle of the current combination.
module fxyz_settle_timer
  import fxyz_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic tick_i,
  output logic last_o
);

  localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST_CNT);

  // Next count: load restarts, tick advances and wraps after the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = last_o ? '0 : cnt_q + SETTLE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fxyz_sweep_ctrl.sv
// Sweep controller: steps {x,y,z} through all 8 combinations, waits
// SETTLE_CYCLES per combination, and captures the evaluator result s.
// Optional golden-table compare enabled by defining FXYZ_CHECK_EN.
module fxyz_sweep_ctrl
  import fxyz_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             s,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic             table_valid,
  output logic [7:0]       table_out,
  output logic             mismatch
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       table_q, table_d;
  logic             valid_q, valid_d;
  logic             settle_load, settle_tick, settle_last;

  fxyz_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (reset),
    .load_i (settle_load),
    .tick_i (settle_tick),
    .last_o (settle_last)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: abort wins over the final sample, so no write and no DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)                                 state_d = IDLE;
        else if (settle_last && idx_q == IDX_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: clear on start, sample and step idx in RUN.
  always_comb begin
    idx_d       = idx_q;
    table_d     = table_q;
    valid_d     = valid_q;
    settle_load = 1'b0;
    settle_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          table_d     = '0;
          valid_d     = 1'b0;
          settle_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          idx_d = '0;
        end else begin
          settle_tick = 1'b1;
          if (settle_last) begin
            table_d[idx_q] = s;
            idx_d          = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    {x, y, z}   = idx_q;
    idx         = idx_q;
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    table_valid = valid_q;
    table_out   = table_q;
  end

`ifdef FXYZ_CHECK_EN
  logic mismatch_q, mismatch_d;

  // Compare the table being written at the DONE-entry edge; clear on start/abort.
  always_comb begin
    mismatch_d = mismatch_q;
    if ((state_q == IDLE && start) || (state_q == RUN && abort)) begin
      mismatch_d = 1'b0;
    end else if (state_q == RUN && state_d == DONE) begin
      mismatch_d = (table_d != GOLDEN_TABLE);
    end
  end

  // Mismatch flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Self-checking bench for fxyz_sweep_ctrl with SETTLE_CYCLES = 1 and 3.
module tb_fxyz_sweep_ctrl;

  logic clk = 1'b0;
  logic reset, start, abort;
  bit   sel;            // 0: SETTLE_CYCLES=1 instance, 1: SETTLE_CYCLES=3 instance
  logic [7:0] tt;       // evaluator truth table presented to the DUT on s
  logic [7:0] gold;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  logic       x1, y1, z1, s1, busy1, done1, valid1, mm1, start1, abort1;
  logic [2:0] idx1;
  logic [7:0] tab1;
  logic       x3, y3, z3, s3, busy3, done3, valid3, mm3, start3, abort3;
  logic [2:0] idx3;
  logic [7:0] tab3;

  assign s1     = tt[{x1, y1, z1}];
  assign s3     = tt[{x3, y3, z3}];
  assign start1 = start & ~sel;
  assign abort1 = abort & ~sel;
  assign start3 = start & sel;
  assign abort3 = abort & sel;

  fxyz_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .x(x1), .y(y1), .z(z1), .s(s1), .idx(idx1), .busy(busy1), .done(done1),
    .table_valid(valid1), .table_out(tab1), .mismatch(mm1));

  fxyz_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3),
    .x(x3), .y(y3), .z(z3), .s(s3), .idx(idx3), .busy(busy3), .done(done3),
    .table_valid(valid3), .table_out(tab3), .mismatch(mm3));

  logic [2:0] o_xyz, o_idx;
  logic       o_busy, o_done, o_valid, o_mm;
  logic [7:0] o_tab;
  always_comb begin
    o_xyz   = sel ? {x3, y3, z3} : {x1, y1, z1};
    o_idx   = sel ? idx3   : idx1;
    o_busy  = sel ? busy3  : busy1;
    o_done  = sel ? done3  : done1;
    o_valid = sel ? valid3 : valid1;
    o_mm    = sel ? mm3    : mm1;
    o_tab   = sel ? tab3   : tab1;
  end

  function automatic int settle();
    return sel ? 3 : 1;
  endfunction

  function automatic logic exp_mm(input logic [7:0] t);
`ifdef FXYZ_CHECK_EN
    return t != gold;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle 1 (just after the start edge). Checks every RUN cycle and
  // the done cycle; ends in the done cycle.
  task automatic sweep_body(input logic [7:0] exp_tab, input bit noise);
    int S = settle();
    for (int k = 1; k <= 8 * S; k++) begin
      int written = (k - 1) / S;
      logic [7:0] part = exp_tab & 8'((1 << written) - 1);
      n_checks++;
      if (o_idx !== 3'(written) || o_xyz !== 3'(written)) begin
        n_fail++;
        $display("FAIL run_idx k=%0d: idx=%0d xyz=%0d expected %0d", k, o_idx, o_xyz, written);
      end
      n_checks++;
      if ({o_busy, o_done, o_valid, o_mm} !== 4'b1000) begin
        n_fail++;
        $display("FAIL run_flags k=%0d: busy/done/valid/mm=%b expected 1000", k,
                 {o_busy, o_done, o_valid, o_mm});
      end
      n_checks++;
      if (o_tab !== part) begin
        n_fail++;
        $display("FAIL run_partial k=%0d: table=%h expected %h", k, o_tab, part);
      end
      if (noise) start = 1'($urandom);
      tick();
    end
    n_checks++;
    if ({o_busy, o_done, o_valid} !== 3'b011 || o_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL done_cycle S=%0d: busy/done/valid=%b idx=%0d expected 011 idx 0", S,
               {o_busy, o_done, o_valid}, o_idx);
    end
    n_checks++;
    if (o_tab !== exp_tab) begin
      n_fail++;
      $display("FAIL done_table S=%0d: table=%h expected %h", S, o_tab, exp_tab);
    end
    n_checks++;
    if (o_mm !== exp_mm(exp_tab)) begin
      n_fail++;
      $display("FAIL done_mismatch S=%0d: mismatch=%b expected %b", S, o_mm, exp_mm(exp_tab));
    end
  endtask

  // Full single sweep followed by one idle cycle check.
  task automatic one_sweep(input logic [7:0] t, input bit noise);
    tt    = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    sweep_body(t, noise);
    start = 1'b0;
    tick();
    n_checks++;
    if ({o_busy, o_done, o_valid} !== 3'b001 || o_tab !== t || o_mm !== exp_mm(t)) begin
      n_fail++;
      $display("FAIL after_done: busy/done/valid=%b table=%h mm=%b expected 001 %h %b",
               {o_busy, o_done, o_valid}, o_tab, o_mm, t, exp_mm(t));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; tt = gold;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      #0;
      n_checks++;
      if ({o_xyz, o_idx, o_busy, o_done, o_valid, o_mm, o_tab} !== '0) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d: xyz=%b idx=%0d flags=%b table=%h expected all 0",
                 i, o_xyz, o_idx, {o_busy, o_done, o_valid, o_mm}, o_tab);
      end
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      one_sweep(gold, 1'b0);
    end
  endtask

  task automatic test_wrong_eval();
    logic [7:0] zt;
    for (int i = 0; i < 8; i++) zt[i] = 1'(i & 1);
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      one_sweep(zt, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      sel = 1'($urandom);
      one_sweep(8'($urandom), 1'b1);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 2; i++) begin
      int S, off;
      sel = 1'(i);
      S   = settle();
      off = int'($urandom_range(S - 1, 0));
      tt  = gold;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4 * S + off) tick();
      n_checks++;
      if (o_idx !== 3'd4 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_setup: idx=%0d busy=%b expected 4 1", o_idx, o_busy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({o_busy, o_done, o_valid, o_mm} !== 4'b0000 || o_tab !== (gold & 8'h0F)) begin
        n_fail++;
        $display("FAIL abort_result off=%0d: flags=%b table=%h expected 0000 %h", off,
                 {o_busy, o_done, o_valid, o_mm}, o_tab, gold & 8'h0F);
      end
      for (int k = 0; k < 8 * S + 2; k++) begin
        abort = 1'($urandom);
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tab !== (gold & 8'h0F)) begin
          n_fail++;
          $display("FAIL abort_idle k=%0d: done=%b busy=%b table=%h expected 0 0 %h", k,
                   o_done, o_busy, o_tab, gold & 8'h0F);
        end
      end
      abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      int S;
      sel = 1'(i);
      S   = settle();
      tt  = gold;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5 * S) tick();
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({o_xyz, o_idx, o_busy, o_done, o_valid, o_mm, o_tab} !== '0) begin
        n_fail++;
        $display("FAIL reset_async sel=%0d: xyz=%b idx=%0d flags=%b table=%h expected all 0",
                 i, o_xyz, o_idx, {o_busy, o_done, o_valid, o_mm}, o_tab);
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      tick();
      for (int k = 0; k < 8 * S + 3; k++) begin
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_nodone k=%0d: done=%b busy=%b expected 0 0", k, o_done, o_busy);
        end
        tick();
      end
      one_sweep(gold, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      tt  = gold;
      start = 1'b1;
      tick();
      sweep_body(gold, 1'b0);
      tick();
      n_checks++;
      if ({o_busy, o_done, o_valid} !== 3'b001) begin
        n_fail++;
        $display("FAIL b2b_idle: busy/done/valid=%b expected 001", {o_busy, o_done, o_valid});
      end
      tick();
      sweep_body(gold, 1'b0);
      start = 1'b0;
      repeat (2) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++)
      gold[i] = ~(1'(i >> 2) & ~1'(i >> 1)) & 1'(i);
    sel = 1'b0;
    test_reset();
    test_basic();
    test_wrong_eval();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
